pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the write enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It handles three cases: load-use hazards, taken-branch flushes, and multi-cycle data-memory accesses through a ready handshake with timeout. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on dmem_ready before error; 0 disables timeout
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  pipeline clock
rst  in  1  reset, synchronous, active-high
id_ex_memread  in  1  instruction in EX is a load
id_ex_rt  in  5  load destination register in EX
if_id_rs  in  5  rs of instruction in ID
if_id_rt  in  5  rt of instruction in ID
if_id_uses_rt  in  1  ID instruction reads rt as a source
branch_taken  in  1  branch/jump resolved taken in EX
dmem_req  in  1  EX/MEM instruction accesses data memory this cycle
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_write  out  1  ID/EX load enable
id_ex_bubble  out  1  ID/EX loads zeroed controls
ex_mem_write  out  1  EX/MEM load enable
mem_wb_bubble  out  1  MEM/WB loads W=2'b00 (no writeback)
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (ports clk, rst). On rst: state=RUN, wait_cnt=0, stall_cnt=0, mem_err=0.
- Outputs while rst=1: pc_write, if_id_write, id_ex_write, ex_mem_write all 0; if_id_flush, id_ex_bubble, mem_wb_bubble all 1.
- Control outputs are combinational from state and inputs, giving same-cycle effect. mem_err and stall_cnt are registered.
- States: RUN, MEM_WAIT, ERR.
- RUN default: all write enables 1, all flush/bubble 0.
- RUN, priority 1 (highest), dmem_req=1 and dmem_ready=0: freeze. All write enables 0, mem_wb_bubble=1. Next state MEM_WAIT, wait_cnt<=1.
- RUN, priority 2, branch_taken=1: if_id_flush=1, id_ex_bubble=1, pc_write=1. If branch_taken and load-use are both asserted, branch wins.
- RUN, priority 3, load-use: id_ex_memread=1, id_ex_rt!=0, and (id_ex_rt==if_id_rs, or id_ex_rt==if_id_rt with if_id_uses_rt=1). Response: pc_write=0, if_id_write=0, id_ex_bubble=1; EX/MEM and MEM/WB advance. Hazard lasts exactly 1 cycle because the load leaves EX.
- RUN, dmem_req=1 with dmem_ready=1: zero-wait access, behaves as default/other priorities.
- MEM_WAIT, dmem_ready=0: freeze as in priority 1. wait_cnt increments.
  - If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT-1 (so MEM_TIMEOUT cycles total without ready): next state ERR, mem_err<=1.
- MEM_WAIT, dmem_ready=1: all write enables 1, mem_wb_bubble=0, so the result is captured. Next state RUN, wait_cnt<=0. Branch and load-use are not evaluated this cycle; they are re-evaluated next cycle in RUN.
- ERR: permanent freeze with mem_wb_bubble=1. mem_err stays 1 until rst. dmem_ready is ignored.
- stall_cnt: increments by 1 each non-reset cycle with pc_write=0. Saturates at all-ones with no wrap.
- rst mid-MEM_WAIT or in ERR: returns to RUN next edge; no partial state is retained.

Decomposition:
- Shared pipeline package holds:
  - state encoding RUN=2'b00, MEM_WAIT=2'b01, ERR=2'b10
  - REG_ZERO=5'd0
  - W_NONE=2'b00, the bubble control value used by MEM/WB
- One natural combinational sub-module, load_use_detect: takes id_ex_memread, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt and outputs hazard.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rt=5'd8, if_id_rs=5'd8 -> for 1 cycle pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1. stall_cnt 0->1. With id_ex_rt=0, no stall.
- rt gating: id_ex_rt=9, if_id_rt=9, if_id_uses_rt=0 -> no stall. With if_id_uses_rt=1 -> stall.
- Branch vs load-use: branch_taken=1 with load-use match -> if_id_flush=1, id_ex_bubble=1, pc_write=1, stall_cnt unchanged.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high -> freeze with mem_wb_bubble=1 for 3 cycles. Enables return in the 4th cycle; stall_cnt=3. Back to RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_err=1 after 4 freeze cycles and stays 1. Freeze persists after dmem_ready=1. rst clears to RUN and mem_err=0.
- Reset mid-wait: rst asserted in MEM_WAIT -> on that cycle enables 0, flushes 1. Next cycle RUN defaults; stall_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e   : controller state encoding (RUN / MEM_WAIT / ERR)
//   REG_ZERO  : hard-wired zero register, never a real hazard source
//   W_NONE    : MEM/WB writeback control value used for a bubble
//   ctrl_t    : bundle of the stage enable / flush / bubble controls
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [1:0] W_NONE   = 2'b00;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  // Normal flow: every stage advances, nothing is squashed.
  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                 id_ex_write: 1'b1, id_ex_bubble: 1'b0,
                                 ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};

  // Whole pipe held; MEM/WB gets a bubble so the pending access never writes back.
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_write: 1'b0, id_ex_bubble: 1'b0,
                                    ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};

  // Held in reset: nothing loads, everything reads as NOP.
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                   id_ex_write: 1'b0, id_ex_bubble: 1'b1,
                                   ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};

  // W field the MEM/WB register should load given the bubble control.
  function automatic logic [1:0] mem_wb_w(input logic bubble, input logic [1:0] w_in);
    return bubble ? W_NONE : w_in;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle between the datapath and the controller.
//   master : datapath side, drives hazard/memory status, consumes controls
//   slave  : controller side
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_ex_memread;
  logic [4:0]       id_ex_rt;
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             if_id_uses_rt;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_write;
  logic             mem_wb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_ex_memread, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
           branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, mem_err, stall_cnt
  );

  modport slave (
    input  id_ex_memread, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
           branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detect: the load in EX writes a register that the
// instruction in ID reads. rt only counts when ID actually sources it.
//   id_ex_memread, id_ex_rt : load in EX and its destination
//   if_id_rs, if_id_rt      : ID source registers
//   if_id_uses_rt           : ID reads rt as a source
//   hazard                  : stall required this cycle
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       id_ex_memread,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       if_id_uses_rt,
  output logic       hazard
);
  logic rs_match;
  logic rt_match;

  assign rs_match = (id_ex_rt == if_id_rs);
  assign rt_match = (id_ex_rt == if_id_rt) && if_id_uses_rt;
  assign hazard   = id_ex_memread && (id_ex_rt != REG_ZERO) && (rs_match || rt_match);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard inputs in, stage controls / mem_err / stall_cnt out
//
// state    | meaning
// RUN      | normal flow; memory stall > branch flush > load-use stall
// MEM_WAIT | data access outstanding, whole pipe frozen until dmem_ready
// ERR      | memory timed out, pipe frozen until reset
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_q;
  ctrl_t             ctrl;
  logic              hazard;

  load_use_detect u_load_use_detect (
    .id_ex_memread (hz.id_ex_memread),
    .id_ex_rt      (hz.id_ex_rt),
    .if_id_rs      (hz.if_id_rs),
    .if_id_rt      (hz.if_id_rt),
    .if_id_uses_rt (hz.if_id_uses_rt),
    .hazard        (hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      if (!ctrl.pc_write && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    ctrl      = CTRL_RUN;
    unique case (state_q)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          // The cycle the miss is seen already counts as the first wait cycle.
          ctrl    = CTRL_FREEZE;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else if (hz.branch_taken) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end else if (hazard) begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_write  = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hz.dmem_ready) begin
          ctrl   = CTRL_FREEZE;
          wait_d = wait_q + WAIT_W'(1);
          if ((MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end
        end else begin
          // Release cycle: plain RUN controls; branch/load-use wait a cycle.
          state_d = RUN;
          wait_d  = '0;
        end
      end
      ERR: ctrl = CTRL_FREEZE;
      default: begin
        ctrl    = CTRL_FREEZE;
        state_d = RUN;
      end
    endcase
    if (rst) ctrl = CTRL_RESET;
  end

  assign hz.pc_write      = ctrl.pc_write;
  assign hz.if_id_write   = ctrl.if_id_write;
  assign hz.if_id_flush   = ctrl.if_id_flush;
  assign hz.id_ex_write   = ctrl.id_ex_write;
  assign hz.id_ex_bubble  = ctrl.id_ex_bubble;
  assign hz.ex_mem_write  = ctrl.ex_mem_write;
  assign hz.mem_wb_bubble = ctrl.mem_wb_bubble;
  assign hz.mem_err       = mem_err_q;
  assign hz.stall_cnt     = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int TB_CNT_W   = 4;
  localparam int TB_TIMEOUT = 4;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble}
  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_RESET  = 7'b0010101;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;
  localparam logic [6:0] C_BRANCH = 7'b1111110;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic [TB_CNT_W-1:0] exp_stall;

  pipeline_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) hif ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  wire [6:0] ctrl_obs = {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_write,
                         hif.id_ex_bubble, hif.ex_mem_write, hif.mem_wb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    hif.id_ex_memread = 1'b0;
    hif.id_ex_rt      = 5'd0;
    hif.if_id_rs      = 5'd0;
    hif.if_id_rt      = 5'd0;
    hif.if_id_uses_rt = 1'b0;
    hif.branch_taken  = 1'b0;
    hif.dmem_req      = 1'b0;
    hif.dmem_ready    = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    #1;
    tests_run++;
    if (ctrl_obs !== C_RESET) begin
      tests_failed++;
      $display("FAIL reset_ctrl got %b want %b", ctrl_obs, C_RESET);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (ctrl_obs !== C_RUN) begin
      tests_failed++;
      $display("FAIL reset_release_ctrl got %b want %b", ctrl_obs, C_RUN);
    end
    tests_run++;
    if (hif.mem_err !== 1'b0 || hif.stall_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_regs got err=%b cnt=%0d want err=0 cnt=0", hif.mem_err, hif.stall_cnt);
    end
    exp_stall = '0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    hif.id_ex_memread = 1'b1; hif.id_ex_rt = 5'd8; hif.if_id_rs = 5'd8;
    #1;
    tests_run++;
    if (ctrl_obs !== C_LDUSE) begin
      tests_failed++;
      $display("FAIL load_use_ctrl got %b want %b", ctrl_obs, C_LDUSE);
    end
    exp_stall++;
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++;
    if (ctrl_obs !== C_RUN || hif.stall_cnt !== exp_stall) begin
      tests_failed++;
      $display("FAIL load_use_after got ctrl=%b cnt=%0d want ctrl=%b cnt=%0d",
               ctrl_obs, hif.stall_cnt, C_RUN, exp_stall);
    end
    @(negedge clk);
    hif.id_ex_memread = 1'b1; hif.id_ex_rt = 5'd0; hif.if_id_rs = 5'd0;
    #1;
    tests_run++;
    if (ctrl_obs !== C_RUN) begin
      tests_failed++;
      $display("FAIL load_use_r0 got %b want %b", ctrl_obs, C_RUN);
    end
  endtask

  task automatic test_rt_gating();
    @(negedge clk);
    drive_idle();
    hif.id_ex_memread = 1'b1; hif.id_ex_rt = 5'd9; hif.if_id_rs = 5'd3;
    hif.if_id_rt = 5'd9; hif.if_id_uses_rt = 1'b0;
    #1;
    tests_run++;
    if (ctrl_obs !== C_RUN) begin
      tests_failed++;
      $display("FAIL rt_unused got %b want %b", ctrl_obs, C_RUN);
    end
    @(negedge clk);
    hif.if_id_uses_rt = 1'b1;
    #1;
    tests_run++;
    if (ctrl_obs !== C_LDUSE) begin
      tests_failed++;
      $display("FAIL rt_used got %b want %b", ctrl_obs, C_LDUSE);
    end
    exp_stall++;
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++;
    if (hif.stall_cnt !== exp_stall) begin
      tests_failed++;
      $display("FAIL rt_stall_cnt got %0d want %0d", hif.stall_cnt, exp_stall);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    hif.id_ex_memread = 1'b1; hif.id_ex_rt = 5'd8; hif.if_id_rs = 5'd8;
    hif.branch_taken = 1'b1;
    #1;
    tests_run++;
    if (ctrl_obs !== C_BRANCH) begin
      tests_failed++;
      $display("FAIL branch_ctrl got %b want %b", ctrl_obs, C_BRANCH);
    end
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++;
    if (hif.stall_cnt !== exp_stall) begin
      tests_failed++;
      $display("FAIL branch_stall_cnt got %0d want %0d", hif.stall_cnt, exp_stall);
    end
  endtask

  task automatic test_mem_wait();
    @(negedge clk);
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctrl_obs !== C_RUN) begin
      tests_failed++;
      $display("FAIL mem_zero_wait got %b want %b", ctrl_obs, C_RUN);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
      #1;
      tests_run++;
      if (ctrl_obs !== C_FREEZE) begin
        tests_failed++;
        $display("FAIL mem_freeze[%0d] got %b want %b", i, ctrl_obs, C_FREEZE);
      end
      exp_stall++;
    end
    // Release cycle: a taken branch here must not be acted on yet.
    @(negedge clk);
    hif.dmem_ready = 1'b1; hif.branch_taken = 1'b1;
    #1;
    tests_run++;
    if (ctrl_obs !== C_RUN) begin
      tests_failed++;
      $display("FAIL mem_release got %b want %b", ctrl_obs, C_RUN);
    end
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++;
    if (ctrl_obs !== C_RUN || hif.stall_cnt !== exp_stall || hif.mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mem_after got ctrl=%b cnt=%0d err=%b want ctrl=%b cnt=%0d err=0",
               ctrl_obs, hif.stall_cnt, hif.mem_err, C_RUN, exp_stall);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
      #1;
      tests_run++;
      if (ctrl_obs !== C_FREEZE || hif.mem_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_wait[%0d] got ctrl=%b err=%b want ctrl=%b err=0",
                 i, ctrl_obs, hif.mem_err, C_FREEZE);
      end
      exp_stall++;
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (ctrl_obs !== C_FREEZE || hif.mem_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_err got ctrl=%b err=%b want ctrl=%b err=1", ctrl_obs, hif.mem_err, C_FREEZE);
    end
    exp_stall++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      hif.dmem_ready = 1'b1;
      #1;
      tests_run++;
      if (ctrl_obs !== C_FREEZE || hif.mem_err !== 1'b1) begin
        tests_failed++;
        $display("FAIL err_sticky[%0d] got ctrl=%b err=%b want ctrl=%b err=1",
                 i, ctrl_obs, hif.mem_err, C_FREEZE);
      end
      exp_stall++;
    end
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    #1;
    tests_run++;
    if (hif.stall_cnt !== exp_stall || ctrl_obs !== C_RESET) begin
      tests_failed++;
      $display("FAIL err_pre_reset got cnt=%0d ctrl=%b want cnt=%0d ctrl=%b",
               hif.stall_cnt, ctrl_obs, exp_stall, C_RESET);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_stall = '0;
    tests_run++;
    if (ctrl_obs !== C_RUN || hif.mem_err !== 1'b0 || hif.stall_cnt !== exp_stall) begin
      tests_failed++;
      $display("FAIL err_cleared got ctrl=%b err=%b cnt=%0d want ctrl=%b err=0 cnt=0",
               ctrl_obs, hif.mem_err, hif.stall_cnt, C_RUN);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (ctrl_obs !== C_RESET) begin
      tests_failed++;
      $display("FAIL mid_wait_reset got %b want %b", ctrl_obs, C_RESET);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    tests_run++;
    if (ctrl_obs !== C_RUN || hif.stall_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_wait_after got ctrl=%b cnt=%0d want ctrl=%b cnt=0", ctrl_obs, hif.stall_cnt, C_RUN);
    end
    exp_stall = '0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (hif.stall_cnt !== 4'hF) begin
      tests_failed++;
      $display("FAIL stall_saturate got %0d want 15", hif.stall_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_stall    = '0;
    rst          = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_rt_gating();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
